// File: rtl/syscall_io_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// syscall_io_unit : WB-side syscall decoder with print FIFO and sticky halt
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module syscall_io_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HALT_CODE  = 10,
  parameter int unsigned PRINT_CODE = 1,
  parameter bit          PRINT_ALL  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       syscall,
  input  logic [DATA_W-1:0]          v0,
  input  logic [DATA_W-1:0]          a0,
  input  logic                       resume,
  output logic                       halt,
  output logic                       stall_out,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          last_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] HALT_V  = DATA_W'(HALT_CODE);
  localparam logic [DATA_W-1:0] PRINT_V = DATA_W'(PRINT_CODE);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              is_halt;
  logic              is_print;
  logic              push;
  logic              pop;

  // Full is taken from the registered count only, so stall never depends on out_ready.
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign is_halt   = syscall & ~halt & (v0 == HALT_V);
  assign is_print  = syscall & ~halt & (v0 != HALT_V) & (PRINT_ALL | (v0 == PRINT_V));
  assign push      = is_print & ~full;
  assign pop       = out_valid & out_ready;
  assign stall_out = is_print & full;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= a0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halt     <= 1'b0;
      last_out <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_out <= a0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new halt request wins over a concurrent resume.
      if (is_halt)     halt <= 1'b1;
      else if (resume) halt <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count <= FULL_CNT);
      assert (!(pop && count == '0));
      assert (!(push && full));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_syscall_io_unit.sv
`default_nettype none
// Directed self-checking bench for syscall_io_unit (PRINT_ALL=1 and PRINT_ALL=0 instances).
module tb_syscall_io_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        syscall = 1'b0, syscall2 = 1'b0;
  logic        resume = 1'b0;
  logic        out_ready = 1'b0, out_ready2 = 1'b0;
  logic [31:0] v0 = '0, a0 = '0;
  logic        halt, stall_out, out_valid, halt2, stall2, out_valid2;
  logic [31:0] out_data, last_out, out_data2, last_out2;
  logic [3:0]  count, count2;
  int          checks = 0;
  int          errors = 0;

  syscall_io_unit #(.DATA_W(32), .DEPTH(8), .HALT_CODE(10), .PRINT_CODE(1), .PRINT_ALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .v0(v0), .a0(a0), .resume(resume),
    .halt(halt), .stall_out(stall_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .last_out(last_out), .count(count));

  syscall_io_unit #(.DATA_W(32), .DEPTH(8), .HALT_CODE(10), .PRINT_CODE(1), .PRINT_ALL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .syscall(syscall2), .v0(v0), .a0(a0), .resume(resume),
    .halt(halt2), .stall_out(stall2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .last_out(last_out2), .count(count2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    syscall = 0; syscall2 = 0; resume = 0; out_ready = 0; out_ready2 = 0;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic do_print(input logic [31:0] val);
    syscall = 1; v0 = 32'd1; a0 = val;
    tick();
    syscall = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    checks++; if (halt !== 1'b0)    begin errors++; $display("FAIL reset_halt: got %b exp 0", halt); end
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", out_data); end
    checks++; if (last_out !== 32'd0) begin errors++; $display("FAIL reset_last: got %h exp 0", last_out); end
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_print();
    do_print(32'h12345678);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL single_data: got %h exp 12345678", out_data); end
    checks++; if (last_out !== 32'h12345678) begin errors++; $display("FAIL single_last: got %h exp 12345678", last_out); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", count); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b exp 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_pop_count: got %0d exp 0", count); end
  endtask

  task automatic test_full_stall();
    for (int i = 1; i <= 8; i++) do_print(32'(i));
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d exp 8", count); end
    checks++; if (out_data !== 32'd1) begin errors++; $display("FAIL full_head: got %0d exp 1", out_data); end
    syscall = 1; v0 = 32'd1; a0 = 32'd9;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL full_stall0: got %b exp 1", stall_out); end
    tick();
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL full_stall1: got %b exp 1", stall_out); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_hold_count: got %0d exp 8", count); end
    out_ready = 1;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL full_stall_ready: got %b exp 1", stall_out); end
    tick();
    out_ready = 0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_pop_count: got %0d exp 7", count); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL full_unstall: got %b exp 0", stall_out); end
    tick();
    syscall = 0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_retry_count: got %0d exp 8", count); end
    checks++; if (last_out !== 32'd9) begin errors++; $display("FAIL full_retry_last: got %0d exp 9", last_out); end
    for (int i = 2; i <= 9; i++) begin
      checks++; if (out_data !== 32'(i)) begin errors++; $display("FAIL full_order: got %0d exp %0d", out_data, i); end
      out_ready = 1;
      tick();
    end
    out_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d exp 0", count); end
  endtask

  task automatic test_halt();
    do_print(32'd11);
    syscall = 1; v0 = 32'd5; a0 = 32'd22;
    tick();
    syscall = 1; v0 = 32'd10; a0 = 32'd33;
    tick();
    syscall = 0;
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b exp 1", halt); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL halt_nopush: got %0d exp 2", count); end
    syscall = 1; v0 = 32'd1; a0 = 32'd99;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL halt_nostall: got %b exp 0", stall_out); end
    tick();
    syscall = 0;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL halt_ignored: got %0d exp 2", count); end
    checks++; if (last_out !== 32'd22) begin errors++; $display("FAIL halt_last: got %0d exp 22", last_out); end
    checks++; if (out_data !== 32'd11) begin errors++; $display("FAIL halt_drain0: got %0d exp 11", out_data); end
    out_ready = 1;
    tick();
    checks++; if (out_data !== 32'd22) begin errors++; $display("FAIL halt_drain1: got %0d exp 22", out_data); end
    tick();
    out_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL halt_drained: got %0d exp 0", count); end
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b exp 1", halt); end
    resume = 1;
    tick();
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_resume: got %b exp 0", halt); end
    syscall = 1; v0 = 32'd10;
    tick();
    syscall = 0;
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_priority: got %b exp 1", halt); end
    tick();
    resume = 0;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_resume2: got %b exp 0", halt); end
  endtask

  task automatic test_print_code_only();
    syscall2 = 1; v0 = 32'd4; a0 = 32'd44;
    tick();
    syscall2 = 0;
    checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL pc_v0_4: got %0d exp 0", count2); end
    for (int i = 1; i <= 3; i++) begin
      syscall2 = 1; v0 = 32'd1; a0 = 32'(i);
      tick();
    end
    checks++; if (count2 !== 4'd3) begin errors++; $display("FAIL pc_count3: got %0d exp 3", count2); end
    a0 = 32'd4; out_ready2 = 1;
    tick();
    syscall2 = 0; out_ready2 = 0;
    checks++; if (count2 !== 4'd3) begin errors++; $display("FAIL pc_pushpop_count: got %0d exp 3", count2); end
    checks++; if (out_data2 !== 32'd2) begin errors++; $display("FAIL pc_pushpop_head: got %0d exp 2", out_data2); end
    checks++; if (last_out2 !== 32'd4) begin errors++; $display("FAIL pc_pushpop_last: got %0d exp 4", last_out2); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (out_data2 !== 32'(i)) begin errors++; $display("FAIL pc_order: got %0d exp %0d", out_data2, i); end
      out_ready2 = 1;
      tick();
    end
    out_ready2 = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    int pushed = 0;
    int cyc = 0;
    logic exp_stall, do_push;
    while ((pushed < 20 || q.size() > 0) && cyc < 300) begin
      syscall = (pushed < 20); v0 = 32'd1; a0 = 32'(1000 + pushed);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_stall = syscall && (q.size() == 8);
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL wrap_count: got %0d exp %0d", count, q.size()); end
      checks++; if (stall_out !== exp_stall) begin errors++; $display("FAIL wrap_stall: got %b exp %b", stall_out, exp_stall); end
      do_push = syscall && (q.size() < 8);
      if (out_ready && q.size() > 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL wrap_data: got %0d exp %0d", out_data, q[0]); end
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back(a0);
        pushed++;
      end
      tick();
      cyc++;
    end
    syscall = 0; out_ready = 0;
    checks++; if (cyc >= 300) begin errors++; $display("FAIL wrap_timeout: got %0d cycles exp <300", cyc); end
  endtask

  task automatic test_reset_mid();
    do_print(32'd7);
    do_print(32'd8);
    syscall = 1; v0 = 32'd10;
    tick();
    syscall = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL mid_halt: got %b exp 0", halt); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", out_valid); end
    checks++; if (last_out !== 32'd0) begin errors++; $display("FAIL mid_last: got %h exp 0", last_out); end
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_print();
    test_full_stall();
    test_halt();
    apply_reset();
    test_print_code_only();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
